// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encodings,
// opcode constants and datapath select encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_OR    = 2'd3;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Bundle of every datapath control, so a whole cycle's decode is one value
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       retire;
    } ctrl_t;

    function automatic logic is_supported(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI};
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR opcode and memory handshake in, all
// enables/selects out. The illegal flag exists only under MC_ILLEGAL_TRAP_EN.
interface mc_ctrl_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         opcode;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic [1:0]         pc_source;
    logic [STATE_W-1:0] state;
    logic               retire;
    logic               mem_timeout;
`ifdef MC_ILLEGAL_TRAP_EN
    logic               illegal;
`endif

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, retire, mem_timeout
`ifdef MC_ILLEGAL_TRAP_EN
        , output illegal
`endif
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, retire, mem_timeout
`ifdef MC_ILLEGAL_TRAP_EN
        , input illegal
`endif
    );

endinterface

// File: rtl/mc_ctrl_wait_cnt.sv
// Saturating memory-wait counter; pulses timeout once, on the wait cycle
// whose count reaches MEM_WAIT_MAX (0 disables the pulse).
module mc_wait_cnt #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);
    localparam int CNT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_WAIT_MAX);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(MEM_WAIT_MAX - 1);

    logic [CNT_W-1:0] count;
    logic             waiting;

    assign waiting = rst_n && active && !mem_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || !active || mem_ready) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + CNT_W'(1);
        end
    end

    // The register still holds the previous count, so the limit cycle is LAST
    generate
        if (MEM_WAIT_MAX == 0) begin : g_off
            assign timeout = 1'b0;
        end else begin : g_on
            assign timeout = waiting && (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM. Define MC_ILLEGAL_TRAP_EN to trap unsupported
// opcodes in a HALT state (with an illegal flag) instead of treating them as NOPs.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int STATE_W      = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    mc_ctrl_if.master bus
);
    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    logic   wait_active;
    logic   timeout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:       state_d = S_EXEC_R;
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_BEQ:         state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    OP_ADDI, OP_ORI: state_d = S_EXEC_I;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:        state_d = S_HALT;
`else
                    default:        state_d = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   state_d = bus.mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC_R:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_EXEC_I:   state_d = S_I_WB;
            S_I_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
            S_HALT:     state_d = S_HALT;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore decode of state; only the FETCH/MEM_WR handshake terms see mem_ready
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
`ifndef MC_ILLEGAL_TRAP_EN
                ctrl.retire    = !is_supported(bus.opcode);
`endif
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.retire     = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                ctrl.retire    = bus.mem_ready;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.retire     = 1'b1;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = (bus.opcode == OP_ORI) ? ALU_OR : ALU_ADD;
            end
            S_I_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b0;
                ctrl.retire    = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.retire        = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.retire    = 1'b1;
            end
            default: ctrl = '0;
        endcase
        // A reset cycle looks like an idle FETCH so nothing gets written
        if (!rst_n) begin
            ctrl           = '0;
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
        end
    end

    assign wait_active = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                         (state_q == S_MEM_WR);

    mc_wait_cnt #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_wait_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (wait_active),
        .mem_ready (bus.mem_ready),
        .timeout   (timeout)
    );

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.retire        = ctrl.retire;
    assign bus.mem_timeout   = timeout;
    assign bus.state         = STATE_W'(state_q);

`ifdef MC_ILLEGAL_TRAP_EN
    assign bus.illegal = rst_n && (state_q == S_HALT);
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized scoreboard bench for mc_ctrl: a driver plays instructions and
// queues the expected control word per cycle, a monitor compares each cycle.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    localparam int MEM_WAIT_MAX = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mc_ctrl_if #(.STATE_W(4)) bus ();

    mc_ctrl #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX),
        .STATE_W      (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        ctrl_t  ctrl;
        logic   timeout;
        logic   illegal;
        logic   chk_state;
        state_t state;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         retire_seen = 0;
    int         retire_expected = 0;
    int         wait_run = 0;
    logic [5:0] op_cur = 6'h00;

    function automatic logic bench_supported(input logic [5:0] op);
        return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
               op == 6'h02 || op == 6'h08 || op == 6'h0D;
    endfunction

    // Control word each instruction step should show, straight from the step table
    function automatic ctrl_t step_ctrl(input state_t st, input logic [5:0] op, input logic ready);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH:    begin c.mem_read = 1; c.alu_src_b = 2'd1; c.ir_write = ready; c.pc_write = ready; end
            S_DECODE: begin
                c.alu_src_b = 2'd3;
`ifndef MC_ILLEGAL_TRAP_EN
                c.retire = !bench_supported(op);
`endif
            end
            S_MEM_ADDR: begin c.alu_src_a = 1; c.alu_src_b = 2'd2; end
            S_MEM_RD:   begin c.mem_read = 1; c.i_or_d = 1; end
            S_MEM_WB:   begin c.reg_write = 1; c.mem_to_reg = 1; c.retire = 1; end
            S_MEM_WR:   begin c.mem_write = 1; c.i_or_d = 1; c.retire = ready; end
            S_EXEC_R:   begin c.alu_src_a = 1; c.alu_op = 2'd2; end
            S_R_WB:     begin c.reg_write = 1; c.reg_dst = 1; c.retire = 1; end
            S_EXEC_I:   begin c.alu_src_a = 1; c.alu_src_b = 2'd2; c.alu_op = (op == 6'h0D) ? 2'd3 : 2'd0; end
            S_I_WB:     begin c.reg_write = 1; c.retire = 1; end
            S_BRANCH:   begin c.alu_src_a = 1; c.alu_op = 2'd1; c.pc_write_cond = 1; c.pc_source = 2'd1; c.retire = 1; end
            S_JUMP:     begin c.pc_write = 1; c.pc_source = 2'd2; c.retire = 1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    task automatic apply_stimulus(input logic rst, input logic ready, input exp_t e);
        @(posedge clk);
        #1;
        rst_n         = rst;
        bus.mem_ready = ready;
        bus.opcode    = op_cur;
        exp_q.push_back(e);
    endtask

    task automatic step(input state_t st, input logic ready);
        exp_t e;
        e.ctrl      = step_ctrl(st, op_cur, ready);
        e.illegal   = (st == S_HALT);
        e.chk_state = 1'b1;
        e.state     = st;
        e.timeout   = 1'b0;
        if ((st == S_FETCH || st == S_MEM_RD || st == S_MEM_WR) && !ready) begin
            wait_run++;
            e.timeout = (MEM_WAIT_MAX != 0) && (wait_run == MEM_WAIT_MAX);
        end else begin
            wait_run = 0;
        end
        if (e.ctrl.retire) retire_expected++;
        apply_stimulus(1'b1, ready, e);
    endtask

    task automatic reset_step(input state_t st_before, input logic chk);
        exp_t e;
        e.ctrl           = '0;
        e.ctrl.mem_read  = 1'b1;
        e.ctrl.alu_src_b = 2'd1;
        e.timeout        = 1'b0;
        e.illegal        = 1'b0;
        e.chk_state      = chk;
        e.state          = st_before;
        wait_run         = 0;
        apply_stimulus(1'b0, 1'($urandom_range(0, 1)), e);
    endtask

    task automatic run_instr(input logic [5:0] op, input int fetch_waits, input int mem_waits);
        op_cur = op;
        for (int i = 0; i < fetch_waits; i++) step(S_FETCH, 1'b0);
        step(S_FETCH, 1'b1);
        step(S_DECODE, 1'($urandom_range(0, 1)));
        case (op)
            6'h00: begin step(S_EXEC_R, 1'($urandom_range(0, 1))); step(S_R_WB, 1'($urandom_range(0, 1))); end
            6'h08, 6'h0D: begin step(S_EXEC_I, 1'($urandom_range(0, 1))); step(S_I_WB, 1'($urandom_range(0, 1))); end
            6'h04: step(S_BRANCH, 1'($urandom_range(0, 1)));
            6'h02: step(S_JUMP, 1'($urandom_range(0, 1)));
            6'h23: begin
                step(S_MEM_ADDR, 1'($urandom_range(0, 1)));
                for (int i = 0; i < mem_waits; i++) step(S_MEM_RD, 1'b0);
                step(S_MEM_RD, 1'b1);
                step(S_MEM_WB, 1'($urandom_range(0, 1)));
            end
            6'h2B: begin
                step(S_MEM_ADDR, 1'($urandom_range(0, 1)));
                for (int i = 0; i < mem_waits; i++) step(S_MEM_WR, 1'b0);
                step(S_MEM_WR, 1'b1);
            end
            default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                for (int i = 0; i < 4; i++) step(S_HALT, 1'($urandom_range(0, 1)));
                reset_step(S_HALT, 1'b1);
                reset_step(S_FETCH, 1'b1);
`endif
            end
        endcase
    endtask

    task automatic check_output(input exp_t e);
        ctrl_t act;
        logic  ok;
        act.pc_write      = bus.pc_write;
        act.pc_write_cond = bus.pc_write_cond;
        act.i_or_d        = bus.i_or_d;
        act.mem_read      = bus.mem_read;
        act.mem_write     = bus.mem_write;
        act.ir_write      = bus.ir_write;
        act.reg_dst       = bus.reg_dst;
        act.mem_to_reg    = bus.mem_to_reg;
        act.reg_write     = bus.reg_write;
        act.alu_src_a     = bus.alu_src_a;
        act.alu_src_b     = bus.alu_src_b;
        act.alu_op        = bus.alu_op;
        act.pc_source     = bus.pc_source;
        act.retire        = bus.retire;
        ok = (act === e.ctrl) && (bus.mem_timeout === e.timeout);
        if (e.chk_state && (bus.state !== 4'(e.state))) ok = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
        if (bus.illegal !== e.illegal) ok = 1'b0;
`endif
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL ctrl cycle %0d: got ctrl=%h timeout=%b state=%0d, want ctrl=%h timeout=%b state=%0d",
                     cyc, act, bus.mem_timeout, bus.state, e.ctrl, e.timeout, e.state);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            if (bus.retire === 1'b1) retire_seen++;
            check_output(exp_q.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [5:0] ops [7];
        int         idx;
        int         fw;
        int         mw;
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04;
        ops[4] = 6'h02; ops[5] = 6'h08; ops[6] = 6'h0D;
        bus.opcode    = 6'h00;
        bus.mem_ready = 1'b0;

        reset_step(S_FETCH, 1'b0);
        reset_step(S_FETCH, 1'b1);
        reset_step(S_FETCH, 1'b1);

        run_instr(6'h00, 0, 0);

        // Abort an R-type in EXEC_R with a three-cycle reset
        op_cur = 6'h00;
        step(S_FETCH, 1'b1);
        step(S_DECODE, 1'b1);
        reset_step(S_EXEC_R, 1'b1);
        reset_step(S_FETCH, 1'b1);
        reset_step(S_FETCH, 1'b1);

        run_instr(6'h23, 0, 3);
        run_instr(6'h2B, 0, 0);
        run_instr(6'h04, 0, 0);
        run_instr(6'h02, 0, 0);
        run_instr(6'h00, 20, 0);
        run_instr(6'h08, 0, 0);
        run_instr(6'h0D, 0, 0);
        run_instr(6'h3F, 0, 0);
        run_instr(6'h23, 2, 17);
        run_instr(6'h2B, 1, 16);

        for (int n = 0; n < 150; n++) begin
`ifdef MC_ILLEGAL_TRAP_EN
            idx = $urandom_range(0, 6);
`else
            idx = $urandom_range(0, 7);
`endif
            fw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(14, 18);
            mw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(14, 18);
            if (idx == 7) begin
                logic [5:0] bad;
                bad = 6'($urandom_range(0, 63));
                while (bench_supported(bad)) bad = 6'($urandom_range(0, 63));
                run_instr(bad, fw, 0);
            end else begin
                run_instr(ops[idx], fw, mw);
            end
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expected words left, want 0", exp_q.size());
        end
        checks++;
        if (retire_seen != retire_expected) begin
            errors++;
            $display("[TB] FAIL retire_count: got %0d want %0d", retire_seen, retire_expected);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM that sequences the MIPS CPU datapath.
- Replaces single-cycle combinational decode so PC, IR, register file, ALU and one shared instruction/data memory port are reused across cycles.
- Sits beside the CPU datapath. Consumes the IR opcode and a memory ready handshake; drives every datapath enable and mux select.
- The CPU bench runs it for a fixed number of cycles, so state and retire visibility are exported.

Parameters:
- MEM_WAIT_MAX, 15, max cycles waiting on mem_ready before mem_timeout pulses; 0 disables the timeout.
- STATE_W, 4, width of state encoding.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- i_or_d  out  1  memory address: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- reg_dst  out  1  write address: 0=rt, 1=rd.
- mem_to_reg  out  1  write data: 0=ALUOut, 1=MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0=PC, 1=A.
- alu_src_b  out  2  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
- alu_op  out  2  0=add, 1=sub, 2=funct field, 3=or (ori).
- pc_source  out  2  0=ALU result, 1=ALUOut, 2=jump target.
- state  out  STATE_W  current state, for bench visibility.
- retire  out  1  one-cycle pulse on the last cycle of each instruction.
- mem_timeout  out  1  one-cycle pulse when a wait exceeds MEM_WAIT_MAX.

Behaviour:
- Reset: when rst_n=0 at a clk edge, state<=FETCH and the wait counter clears. All outputs are Moore decodes of state, so every output is 0 during reset except the FETCH set: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
- Reset asserted mid-instruction aborts it. No write enables assert in the reset cycle.
- Supported opcodes: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08, ori 0x0D.
- FETCH:
  - Asserts mem_read, with alu_src_b=1 and alu_op=add.
  - On mem_ready: ir_write=1 and pc_write=1 in that same cycle, then -> DECODE.
  - Otherwise holds, with ir_write and pc_write both 0.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=add (branch target). Next state by opcode:
  - R -> EXEC_R
  - lw/sw -> MEM_ADDR
  - beq -> BRANCH
  - j -> JUMP
  - addi/ori -> EXEC_I
  - other -> FETCH (treated as NOP; retire pulses)
- MEM_ADDR: alu_src_a=1, alu_src_b=2, add. Next: lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD:
  - Outputs: mem_read=1, i_or_d=1.
  - Holds until mem_ready, then -> MEM_WB.
- MEM_WB:
  - Outputs: reg_write=1, mem_to_reg=1, reg_dst=0, retire=1.
  - Next -> FETCH.
- MEM_WR:
  - Outputs: mem_write=1, i_or_d=1.
  - Holds until mem_ready. In the mem_ready cycle retire=1, then -> FETCH.
  - mem_write stays asserted for every wait cycle.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=2. Next -> R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, retire=1. Next -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op=0 (addi) or 3 (ori). Next -> I_WB.
- I_WB: reg_write=1, reg_dst=0, retire=1. Next -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=sub, pc_write_cond=1, pc_source=1, retire=1. Next -> FETCH.
- JUMP: pc_write=1, pc_source=2, retire=1. Next -> FETCH.
- Instruction latencies with zero-wait memory:
  - R, addi, ori: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq, j: 3 cycles
- Wait counter (FETCH, MEM_RD, MEM_WR):
  - Increments each cycle without mem_ready; clears on mem_ready or on leaving the state.
  - Saturates at MEM_WAIT_MAX.
  - mem_timeout pulses once, on the cycle the count reaches MEM_WAIT_MAX.
  - The FSM keeps waiting after the pulse.
- mem_read and mem_write are never both 1.
- Unused encodings of state -> FETCH.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined:
  - Unsupported opcode in DECODE -> HALT state.
  - HALT asserts output illegal=1 (extra 1-bit port, present only under the macro) and all enables 0.
  - HALT is left only by reset.
  - No retire pulse for the faulting instruction.
- Undefined: unsupported opcode behaves as a 2-cycle NOP as above; no illegal port.

Decomposition:
- Shared package/header mc_defs:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI)
  - alu_op, alu_src_b and pc_source encodings
- The datapath and ALU control decoder include the same header.
- One natural sub-module, mc_wait_cnt: the saturating memory-wait counter and timeout pulse generator.

Test Plan:
- Reset, then rst_n=0 held for 3 cycles mid-EXEC_R -> state=FETCH the cycle after release; reg_write never asserted.
- R-type (opcode 0x00), mem_ready tied 1 -> states FETCH, DECODE, EXEC_R, R_WB; reg_write and reg_dst=1 only in cycle 4; retire pulses once.
- lw (0x23) with mem_ready low 3 cycles in MEM_RD -> 8 total cycles; mem_read/i_or_d=1 held 4 cycles; reg_write with mem_to_reg=1 one cycle.
- sw (0x2B) then beq (0x04) then j (0x02), zero-wait -> 4+3+3 cycles; exactly 3 retire pulses; mem_write high 1 cycle; pc_write_cond only in BRANCH; pc_source=2 only in JUMP.
- mem_ready held low in FETCH for 20 cycles, MEM_WAIT_MAX=15 -> single mem_timeout pulse at wait cycle 15; ir_write stays 0 until mem_ready.
- Opcode 0x3F -> without MC_ILLEGAL_TRAP_EN: return to FETCH after 2 cycles. With it: state=HALT and illegal=1 held until reset.
